// File: rtl/alu_operand_stage_rv32i.sv
// alu_operand_stage_rv32i: registered operand-select stage feeding the RV32I adder, two-entry skid buffer
// Ports: clk/rst (sync, active-high), flush; upstream in_valid/in_ready with rs1_data, rs2_data, imm, pc,
// src_a_sel, src_b_sel, sub; downstream out_valid/out_ready with op_a, op_b, op_type.
module alu_operand_stage_rv32i #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    input  logic             src_a_sel,
    input  logic             src_b_sel,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_type
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic             skid_type;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] new_a;
    logic [WIDTH-1:0] new_b;
    logic             new_type;

    // Ready depends only on the skid flag, never on out_ready
    assign in_ready = ~skid_valid & ~rst;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = out_valid & out_ready;
    assign new_a    = src_a_sel ? pc : rs1_data;
    assign new_b    = src_b_sel ? imm : rs2_data;
    // RV32I has no SUBI, so immediate operations always add
    assign new_type = sub & ~src_b_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_type    <= 1'b0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_type  <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            // accept never coincides with a full skid, so these cover every legal case
            out_valid  <= accept | skid_valid | (out_valid & ~drain);
            skid_valid <= (accept & out_valid & ~drain) | (skid_valid & ~drain);
            if (drain & skid_valid) begin
                op_a    <= skid_a;
                op_b    <= skid_b;
                op_type <= skid_type;
            end else if (accept & (~out_valid | drain)) begin
                op_a    <= new_a;
                op_b    <= new_b;
                op_type <= new_type;
            end
            if (accept & out_valid & ~drain) begin
                skid_a    <= new_a;
                skid_b    <= new_b;
                skid_type <= new_type;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_stage_rv32i.sv
// tb_alu_operand_stage_rv32i: directed and random checks of the operand stage against a queue model
module tb_alu_operand_stage_rv32i;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic        src_a_sel = 1'b0;
    logic        src_b_sel = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_type;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        t;
    } op_t;

    op_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    alu_operand_stage_rv32i #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .op_type(op_type)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of at most two operations; the head is what the adder sees
    always @(posedge clk) begin
        automatic bit drn = q.size() > 0 && out_ready;
        automatic bit acc = in_valid && q.size() < 2 && !flush && !rst;
        automatic op_t o;
        o.a = src_a_sel ? pc : rs1_data;
        o.b = src_b_sel ? imm : rs2_data;
        o.t = sub && !src_b_sel;
        if (rst || flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(o);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2 && !rst)});
            check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0) begin
                check("op_a", op_a, q[0].a);
                check("op_b", op_b, q[0].b);
                check("op_type", {31'b0, op_type}, {31'b0, q[0].t});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p,
                         input logic sa, input logic sb, input logic sb_sub);
        in_valid = v; rs1_data = r1; rs2_data = r2; imm = im; pc = p;
        src_a_sel = sa; src_b_sel = sb; sub = sb_sub;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        check("rst in_ready", {31'b0, in_ready}, 32'd0);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst op_a", op_a, 32'd0);
        check("rst op_b", op_b, 32'd0);
        check("rst op_type", {31'b0, op_type}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        // single subtract
        drive(1'b1, 32'd5, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        check("single out_valid", {31'b0, out_valid}, 32'd1);
        check("single op_a", op_a, 32'd5);
        check("single op_b", op_b, 32'd3);
        check("single op_type", {31'b0, op_type}, 32'd1);
        step();
        // immediate forces add
        drive(1'b1, 32'd7, 32'd9, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        check("imm op_a", op_a, 32'd7);
        check("imm op_b", op_b, 32'hFFFF_FFFC);
        check("imm op_type", {31'b0, op_type}, 32'd0);
        step();
        // backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'd0, 32'd0, 32'd0, 32'h100, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'd0, 32'd0, 32'd0, 32'h104, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        check("bp in_ready", {31'b0, in_ready}, 32'd0);
        check("bp op_a", op_a, 32'h100);
        step();
        check("bp hold op_a", op_a, 32'h100);
        out_ready = 1'b1;
        step();
        check("bp drain1 op_a", op_a, 32'h104);
        check("bp drain1 valid", {31'b0, out_valid}, 32'd1);
        check("bp drain1 in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("bp drain2 valid", {31'b0, out_valid}, 32'd0);
        // streaming
        for (int i = 1; i <= 8; i++) begin
            check("stream in_ready", {31'b0, in_ready}, 32'd1);
            drive(1'b1, i, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            step();
            check("stream op_a", op_a, i);
            check("stream valid", {31'b0, out_valid}, 32'd1);
        end
        idle();
        step();
        // flush with both entries full
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        check("flush no ghost", {31'b0, out_valid}, 32'd0);
        // reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        rst = 1'b1;
        step();
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst op_a", op_a, 32'd0);
        check("midrst in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst in_ready after", {31'b0, in_ready}, 32'd1);
        step();
        // random traffic; the per-cycle compare against the model does the checking
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 70, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = $urandom_range(99) < 60;
            flush = $urandom_range(99) < 3;
            rst = $urandom_range(199) < 1;
            step();
        end
        idle();
        flush = 1'b0;
        rst = 1'b0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage_rv32i.md
ALU_OPERAND_STAGE_RV32I -- requirements
Module: alu_operand_stage_rv32i

Interface
REQ-001 Parameters: WIDTH, 32, datapath width. The block SHALL be verified only at 32.
REQ-002 The block SHALL have one clock and synchronous active-high reset. Ports: clk input 1, rising-edge clock; rst input 1, synchronous, active-high reset.
REQ-003 flush input 1: discard all held operations.
REQ-004 in_valid input 1: upstream (decode) presents an operation.
REQ-005 in_ready output 1: the stage can accept an operation.
REQ-006 rs1_data input WIDTH: register-file operand 1.
REQ-007 rs2_data input WIDTH: register-file operand 2.
REQ-008 imm input WIDTH: sign-extended immediate.
REQ-009 pc input WIDTH: instruction address.
REQ-010 src_a_sel input 1: 0 selects rs1_data, 1 selects pc.
REQ-011 src_b_sel input 1: 0 selects rs2_data, 1 selects imm.
REQ-012 sub input 1: 0 add, 1 subtract.
REQ-013 out_valid output 1: op_a, op_b and op_type are valid for the downstream adder.
REQ-014 out_ready input 1: downstream consumes the operation.
REQ-015 op_a output WIDTH: adder in1.
REQ-016 op_b output WIDTH: adder in2.
REQ-017 op_type output 1: adder type (0 add, 1 sub).

Function
REQ-018 An accept SHALL occur on a rising edge where in_valid=1, in_ready=1, rst=0 and flush=0.
REQ-019 At accept, the block SHALL capture op_a = src_a_sel ? pc : rs1_data and op_b = src_b_sel ? imm : rs2_data. Operands SHALL be registered, not passed through combinationally.
REQ-020 At accept, op_type SHALL be captured as sub & ~src_b_sel. Immediate-operand operations are always add, because RV32I has no SUBI.
REQ-021 Storage SHALL be two entries: an output register (out_valid) and a skid register (skid_valid, internal).
REQ-022 in_ready SHALL equal ~skid_valid & ~rst, driven from a register with no combinational path from out_ready.
REQ-023 Latency SHALL be 1 cycle. An accept into an empty stage makes out_valid=1 on the following cycle.
REQ-024 A drain SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-025 Accept with the output empty, or with a simultaneous drain and empty skid: the data SHALL load the output register.
REQ-026 Accept with the output full and no drain: the data SHALL load the skid register, skid_valid=1, and in_ready=0 from the next cycle.
REQ-027 Drain with skid_valid=1: the skid contents SHALL move to the output register on the same edge, skid_valid=0, and out_valid stays 1.
REQ-028 Drain with skid empty and no accept: out_valid SHALL become 0.
REQ-029 While out_valid=1 and out_ready=0, op_a, op_b and op_type SHALL hold stable.
REQ-030 Ordering SHALL be strict FIFO. No operation may be lost or duplicated.
REQ-031 flush=1 SHALL clear out_valid and skid_valid on that edge. An accept in the same cycle is dropped, and in_ready=1 on the next cycle.
REQ-032 flush SHALL have priority over accept and drain. rst SHALL have priority over flush.
REQ-033 Data registers SHALL not be required to clear on flush. Only valid flags clear.

Reset
REQ-034 While rst=1 at a rising edge, the block SHALL set out_valid=0, skid_valid=0, op_a=0, op_b=0 and op_type=0. in_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-035 Reset asserted mid-operation SHALL discard held and skid operations with no output handshake.

Verification
REQ-036 Single op: rs1=0x0000_0005, rs2=0x0000_0003, sel_a=0, sel_b=0, sub=1 -> next cycle out_valid=1, op_a=5, op_b=3, op_type=1.
REQ-037 Immediate with sub: sel_b=1, imm=0xFFFF_FFFC, sub=1 -> op_b=0xFFFF_FFFC, op_type=0.
REQ-038 Backpressure: out_ready=0, issue ops A=pc 0x100, B=0x104 back-to-back -> in_ready=0 after B, op_a holds 0x100. Raise out_ready -> A then B drain in order on consecutive cycles, and in_ready returns to 1.
REQ-039 Streaming: out_ready=1, in_valid=1 for 8 cycles with op_a=1..8 -> 8 outputs in order, in_ready never 0, one op per cycle.
REQ-040 Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
REQ-041 Reset mid-operation: out_valid=1, skid full, rst=1 for 1 cycle -> out_valid=0, op_a=0, in_ready=0 during reset then 1.
